// File: rtl/act_loader.sv
// Write-side sequencer for the ping-pong activation buffer: packs TM stream bytes per row,
// writes rows into the free bank, hands full banks to the consumer and reclaims them on release.
module act_loader #(
  parameter int TM         = 14,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH:0]   cfg_rows,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [7:0]            s_data,
  input  logic                  s_last,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [TM*8-1:0]       wdata,
  output logic                  bank_sel_wr,
  input  logic                  bank_release,
  input  logic                  bank_release_sel,
  output logic [1:0]            bank_valid,
  output logic                  tile_done,
  output logic                  tile_bank,
  output logic                  busy,
  output logic                  err_last
);

  localparam int BW = (TM > 1) ? $clog2(TM) : 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_BANK = 2'd1;
  localparam logic [1:0] FILL      = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  localparam logic [BW-1:0]       LAST_BYTE = BW'(TM - 1);
  localparam logic [ADDR_WIDTH:0] MAX_ROWS  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_ROW   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] NO_ROWS   = {(ADDR_WIDTH+1){1'b0}};

  logic [1:0]            state_r;
  logic                  wr_bank_r;
  logic [1:0]            bank_valid_r;
  logic [ADDR_WIDTH:0]   rows_r;
  logic [ADDR_WIDTH:0]   row_cnt_r;
  logic [BW-1:0]         byte_cnt_r;
  logic [TM*8-1:0]       pack_r;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] waddr_r;
  logic [TM*8-1:0]       wdata_r;
  logic                  bank_sel_wr_r;
  logic                  s_ready_r;
  logic                  tile_done_r;
  logic                  tile_bank_r;
  logic                  busy_r;
  logic                  err_last_r;

  logic                  acc_s;
  logic                  row_end_s;
  logic                  last_s;
  logic                  start_s;
  logic                  bank_free_s;
  logic [ADDR_WIDTH:0]   rows_cfg_s;
  logic [TM*8-1:0]       row_s;
  logic [1:0]            bank_valid_nxt_s;
  logic [1:0]            state_nxt_s;

  // Byte acceptance, row packing, bank ownership and next-state decode
  always_comb begin
    acc_s       = s_valid & s_ready_r;
    row_end_s   = acc_s && (byte_cnt_r == LAST_BYTE);
    last_s      = row_end_s && (row_cnt_r == (rows_r - ONE_ROW));
    start_s     = (state_r == IDLE) && cfg_start && (cfg_rows != NO_ROWS);
    bank_free_s = !bank_valid_r[wr_bank_r] ||
                  (bank_release && (bank_release_sel == wr_bank_r));
    rows_cfg_s  = (cfg_rows > MAX_ROWS) ? MAX_ROWS : cfg_rows;

    row_s = pack_r;
    for (int i = 0; i < TM; i++) begin
      if (byte_cnt_r == BW'(i)) begin
        row_s[8*i +: 8] = s_data;
      end else begin
        row_s[8*i +: 8] = pack_r[8*i +: 8];
      end
    end

    // A commit and a release on the same bank resolve in favour of the commit
    bank_valid_nxt_s = bank_valid_r;
    if (bank_release) begin
      bank_valid_nxt_s[bank_release_sel] = 1'b0;
    end else begin
      bank_valid_nxt_s = bank_valid_r;
    end
    if (state_r == DONE) begin
      bank_valid_nxt_s[wr_bank_r] = 1'b1;
    end else begin
      bank_valid_nxt_s = bank_valid_nxt_s;
    end

    state_nxt_s = state_r;
    case (state_r)
      IDLE:      state_nxt_s = start_s ? WAIT_BANK : IDLE;
      WAIT_BANK: state_nxt_s = bank_free_s ? FILL : WAIT_BANK;
      FILL:      state_nxt_s = last_s ? DONE : FILL;
      DONE:      state_nxt_s = IDLE;
      default:   state_nxt_s = IDLE;
    endcase
  end

  // Sequencer state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      wr_bank_r     <= 1'b0;
      bank_valid_r  <= 2'b00;
      rows_r        <= NO_ROWS;
      row_cnt_r     <= NO_ROWS;
      byte_cnt_r    <= {BW{1'b0}};
      pack_r        <= {(TM*8){1'b0}};
      we_r          <= 1'b0;
      waddr_r       <= {ADDR_WIDTH{1'b0}};
      wdata_r       <= {(TM*8){1'b0}};
      bank_sel_wr_r <= 1'b0;
      s_ready_r     <= 1'b0;
      tile_done_r   <= 1'b0;
      tile_bank_r   <= 1'b0;
      busy_r        <= 1'b0;
      err_last_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      s_ready_r    <= (state_nxt_s == FILL);
      busy_r       <= (state_nxt_s != IDLE);
      bank_valid_r <= bank_valid_nxt_s;
      we_r         <= row_end_s;
      tile_done_r  <= (state_r == DONE);

      if (row_end_s) begin
        waddr_r       <= row_cnt_r[ADDR_WIDTH-1:0];
        wdata_r       <= row_s;
        bank_sel_wr_r <= wr_bank_r;
      end

      if (start_s) begin
        rows_r     <= rows_cfg_s;
        row_cnt_r  <= NO_ROWS;
        byte_cnt_r <= {BW{1'b0}};
        err_last_r <= 1'b0;
      end else if (acc_s) begin
        pack_r     <= row_s;
        byte_cnt_r <= row_end_s ? {BW{1'b0}} : (byte_cnt_r + {{(BW-1){1'b0}}, 1'b1});
        row_cnt_r  <= row_end_s ? (row_cnt_r + ONE_ROW) : row_cnt_r;
        // s_last must coincide exactly with the final byte of the final row
        if (s_last != last_s) begin
          err_last_r <= 1'b1;
        end
      end

      if (state_r == DONE) begin
        tile_bank_r <= wr_bank_r;
        wr_bank_r   <= ~wr_bank_r;
      end
    end
  end

  assign s_ready     = s_ready_r;
  assign we          = we_r;
  assign waddr       = waddr_r;
  assign wdata       = wdata_r;
  assign bank_sel_wr = bank_sel_wr_r;
  assign bank_valid  = bank_valid_r;
  assign tile_done   = tile_done_r;
  assign tile_bank   = tile_bank_r;
  assign busy        = busy_r;
  assign err_last    = err_last_r;

endmodule
